// File: rtl/batch_dispatcher.sv
// Walks the SBR -> SRR -> request linked lists of a built batch and issues requests in order.
// Define BATCH_DISPATCH_STATS_EN to add the row-open and issued-request counters.
`ifndef SBR_ID_WIDTH
`define SBR_ID_WIDTH 4
`endif
`ifndef SRR_ID_WIDTH
`define SRR_ID_WIDTH 6
`endif
`ifndef REQUEST_ID_WIDTH
`define REQUEST_ID_WIDTH 6
`endif
`ifndef BANK_GROUP_WIDTH
`define BANK_GROUP_WIDTH 2
`endif
`ifndef BANK_WIDTH
`define BANK_WIDTH 2
`endif
`ifndef ROW_WIDTH
`define ROW_WIDTH 16
`endif

module batch_dispatcher #(
  parameter int unsigned RD_LAT = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  input  logic [`SBR_ID_WIDTH-1:0]       critical_path_sbr,
  input  logic [`SBR_ID_WIDTH-1:0]       sbr_num_entries,
  output logic [`SBR_ID_WIDTH-1:0]       sbr_rd_addr,
  input  logic [`SRR_ID_WIDTH-1:0]       sbr_rd_head_srr,
  input  logic [`SRR_ID_WIDTH-1:0]       sbr_rd_row_count,
  output logic [`SRR_ID_WIDTH-1:0]       srr_rd_addr,
  input  logic [`REQUEST_ID_WIDTH-1:0]   srr_rd_head_req,
  input  logic [`REQUEST_ID_WIDTH-1:0]   srr_rd_count,
  input  logic [`SRR_ID_WIDTH-1:0]       srr_rd_next,
  output logic [`REQUEST_ID_WIDTH-1:0]   req_rd_addr,
  input  logic [`BANK_GROUP_WIDTH-1:0]   req_rd_bank_group,
  input  logic [`BANK_WIDTH-1:0]         req_rd_bank,
  input  logic [`ROW_WIDTH-1:0]          req_rd_row,
  input  logic [`REQUEST_ID_WIDTH-1:0]   req_rd_next,
  output logic                           issue_valid,
  input  logic                           issue_ready,
  output logic [`REQUEST_ID_WIDTH-1:0]   issue_req_id,
  output logic [`BANK_GROUP_WIDTH-1:0]   issue_bank_group,
  output logic [`BANK_WIDTH-1:0]         issue_bank,
  output logic [`ROW_WIDTH-1:0]          issue_row,
  output logic                           issue_row_open,
  output logic                           issue_last
`ifdef BATCH_DISPATCH_STATS_EN
  ,
  output logic [`SRR_ID_WIDTH-1:0]       stat_rows_opened,
  output logic [`REQUEST_ID_WIDTH-1:0]   stat_reqs_issued
`endif
);

  localparam int unsigned SW = `SBR_ID_WIDTH;
  localparam int unsigned RW = `SRR_ID_WIDTH;
  localparam int unsigned QW = `REQUEST_ID_WIDTH;
  localparam logic [1:0]    WaitLast = 2'(RD_LAT - 1);
  localparam logic [SW-1:0] SbrOne   = SW'(1);
  localparam logic [SW:0]   SbrWOne  = (SW + 1)'(1);
  localparam logic [RW-1:0] RowOne   = RW'(1);
  localparam logic [QW-1:0] ReqOne   = QW'(1);

  typedef enum logic [3:0] {
    StIdle, StSelSbr, StRdSbr, StRdSrr, StRdReq, StIssue, StAdvSrr, StNextSbr, StDone
  } state_e;

  state_e                       state_q, state_d;
  logic [1:0]                   wait_q, wait_d;
  logic                         first_q, first_d;
  logic [SW-1:0]                sbr_idx_q, sbr_idx_d;
  logic [RW-1:0]                rows_left_q, rows_left_d;
  logic [QW-1:0]                reqs_left_q, reqs_left_d;
  logic [RW-1:0]                next_srr_q, next_srr_d;
  logic [QW-1:0]                next_req_q, next_req_d;
  logic                         row_open_q, row_open_d;
  logic [SW-1:0]                sbr_addr_q, sbr_addr_d;
  logic [RW-1:0]                srr_addr_q, srr_addr_d;
  logic [QW-1:0]                req_addr_q, req_addr_d;
  logic                         valid_q, valid_d;
  logic [QW-1:0]                id_q, id_d;
  logic [`BANK_GROUP_WIDTH-1:0] bg_q, bg_d;
  logic [`BANK_WIDTH-1:0]       bank_q, bank_d;
  logic [`ROW_WIDTH-1:0]        row_q, row_d;
  logic                         open_q, open_d;
  logic                         last_q, last_d;

  logic          rd_done;
  logic [SW-1:0] idx_sel;
  logic [SW:0]   idx_inc, idx_after;
  logic          no_more_sbr;
  logic          accept;

  assign rd_done = (wait_q == WaitLast);
  assign idx_sel = (sbr_idx_q == critical_path_sbr) ? sbr_idx_q + SbrOne : sbr_idx_q;
  // Next SBR index the walk would visit after the current one, skipping the critical SBR.
  assign idx_inc   = {1'b0, sbr_idx_q} + SbrWOne;
  assign idx_after = (idx_inc == {1'b0, critical_path_sbr}) ? idx_inc + SbrWOne : idx_inc;
  assign no_more_sbr = first_q ? (sbr_num_entries <= SbrOne)
                               : (idx_after >= {1'b0, sbr_num_entries});
  assign accept = (state_q == StIssue) && issue_ready;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    first_d     = first_q;
    sbr_idx_d   = sbr_idx_q;
    rows_left_d = rows_left_q;
    reqs_left_d = reqs_left_q;
    next_srr_d  = next_srr_q;
    next_req_d  = next_req_q;
    row_open_d  = row_open_q;
    sbr_addr_d  = sbr_addr_q;
    srr_addr_d  = srr_addr_q;
    req_addr_d  = req_addr_q;
    valid_d     = valid_q;
    id_d        = id_q;
    bg_d        = bg_q;
    bank_d      = bank_q;
    row_d       = row_q;
    open_d      = open_q;
    last_d      = last_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StSelSbr;
          sbr_idx_d = '0;
          first_d   = 1'b1;
        end
      end
      StSelSbr: begin
        if (first_q && (critical_path_sbr < sbr_num_entries)) begin
          sbr_addr_d = critical_path_sbr;
          wait_d     = '0;
          state_d    = StRdSbr;
        end else begin
          // An out-of-range critical SBR is dropped and the ascending walk starts at once.
          first_d   = 1'b0;
          sbr_idx_d = idx_sel;
          if (idx_sel >= sbr_num_entries) begin
            state_d = StDone;
          end else begin
            sbr_addr_d = idx_sel;
            wait_d     = '0;
            state_d    = StRdSbr;
          end
        end
      end
      StRdSbr: begin
        if (rd_done) begin
          rows_left_d = sbr_rd_row_count;
          srr_addr_d  = sbr_rd_head_srr;
          wait_d      = '0;
          state_d     = (sbr_rd_row_count == '0) ? StNextSbr : StRdSrr;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      StRdSrr: begin
        if (rd_done) begin
          reqs_left_d = srr_rd_count;
          next_srr_d  = srr_rd_next;
          row_open_d  = 1'b1;
          req_addr_d  = srr_rd_head_req;
          wait_d      = '0;
          state_d     = (srr_rd_count == '0) ? StAdvSrr : StRdReq;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      StRdReq: begin
        if (rd_done) begin
          valid_d    = 1'b1;
          id_d       = req_addr_q;
          bg_d       = req_rd_bank_group;
          bank_d     = req_rd_bank;
          row_d      = req_rd_row;
          next_req_d = req_rd_next;
          open_d     = row_open_q;
          last_d     = (reqs_left_q == ReqOne) && (rows_left_q == RowOne) && no_more_sbr;
          state_d    = StIssue;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      StIssue: begin
        if (issue_ready) begin
          valid_d     = 1'b0;
          row_open_d  = 1'b0;
          reqs_left_d = reqs_left_q - ReqOne;
          if (reqs_left_q != ReqOne) begin
            req_addr_d = next_req_q;
            wait_d     = '0;
            state_d    = StRdReq;
          end else begin
            state_d = StAdvSrr;
          end
        end
      end
      StAdvSrr: begin
        rows_left_d = rows_left_q - RowOne;
        if (rows_left_q != RowOne) begin
          srr_addr_d = next_srr_q;
          wait_d     = '0;
          state_d    = StRdSrr;
        end else begin
          state_d = StNextSbr;
        end
      end
      StNextSbr: begin
        if (first_q) begin
          first_d = 1'b0;
        end else begin
          sbr_idx_d = sbr_idx_q + SbrOne;
        end
        state_d = StSelSbr;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wait_q      <= '0;
      first_q     <= 1'b0;
      sbr_idx_q   <= '0;
      rows_left_q <= '0;
      reqs_left_q <= '0;
      next_srr_q  <= '0;
      next_req_q  <= '0;
      row_open_q  <= 1'b0;
      sbr_addr_q  <= '0;
      srr_addr_q  <= '0;
      req_addr_q  <= '0;
      valid_q     <= 1'b0;
      id_q        <= '0;
      bg_q        <= '0;
      bank_q      <= '0;
      row_q       <= '0;
      open_q      <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      first_q     <= first_d;
      sbr_idx_q   <= sbr_idx_d;
      rows_left_q <= rows_left_d;
      reqs_left_q <= reqs_left_d;
      next_srr_q  <= next_srr_d;
      next_req_q  <= next_req_d;
      row_open_q  <= row_open_d;
      sbr_addr_q  <= sbr_addr_d;
      srr_addr_q  <= srr_addr_d;
      req_addr_q  <= req_addr_d;
      valid_q     <= valid_d;
      id_q        <= id_d;
      bg_q        <= bg_d;
      bank_q      <= bank_d;
      row_q       <= row_d;
      open_q      <= open_d;
      last_q      <= last_d;
    end
  end

  assign busy             = (state_q != StIdle);
  assign done             = (state_q == StDone);
  assign sbr_rd_addr      = sbr_addr_q;
  assign srr_rd_addr      = srr_addr_q;
  assign req_rd_addr      = req_addr_q;
  assign issue_valid      = valid_q;
  assign issue_req_id     = id_q;
  assign issue_bank_group = bg_q;
  assign issue_bank       = bank_q;
  assign issue_row        = row_q;
  assign issue_row_open   = open_q;
  assign issue_last       = last_q;

`ifdef BATCH_DISPATCH_STATS_EN
  logic [RW-1:0] stat_rows_q;
  logic [QW-1:0] stat_reqs_q;

  always_ff @(posedge clk) begin
    if (rst || ((state_q == StIdle) && start)) begin
      stat_rows_q <= '0;
      stat_reqs_q <= '0;
    end else if (accept) begin
      stat_reqs_q <= stat_reqs_q + ReqOne;
      if (open_q) begin
        stat_rows_q <= stat_rows_q + RowOne;
      end
    end
  end

  assign stat_rows_opened = stat_rows_q;
  assign stat_reqs_issued = stat_reqs_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_batch_dispatcher.sv
// Directed bench for batch_dispatcher: table of expected issue sequences plus
// hand-written backpressure and mid-dispatch reset sequences.
`ifndef SBR_ID_WIDTH
`define SBR_ID_WIDTH 4
`endif
`ifndef SRR_ID_WIDTH
`define SRR_ID_WIDTH 6
`endif
`ifndef REQUEST_ID_WIDTH
`define REQUEST_ID_WIDTH 6
`endif
`ifndef BANK_GROUP_WIDTH
`define BANK_GROUP_WIDTH 2
`endif
`ifndef BANK_WIDTH
`define BANK_WIDTH 2
`endif
`ifndef ROW_WIDTH
`define ROW_WIDTH 16
`endif

module tb_batch_dispatcher;
  localparam int SW   = `SBR_ID_WIDTH;
  localparam int RW   = `SRR_ID_WIDTH;
  localparam int QW   = `REQUEST_ID_WIDTH;
  localparam int NVEC = 19;

  logic                         clk = 1'b0;
  logic                         rst, start, busy, done;
  logic [SW-1:0]                critical_path_sbr, sbr_num_entries, sbr_rd_addr;
  logic [RW-1:0]                sbr_rd_head_srr, sbr_rd_row_count, srr_rd_addr, srr_rd_next;
  logic [QW-1:0]                srr_rd_head_req, srr_rd_count, req_rd_addr, req_rd_next;
  logic [`BANK_GROUP_WIDTH-1:0] req_rd_bank_group, issue_bank_group;
  logic [`BANK_WIDTH-1:0]       req_rd_bank, issue_bank;
  logic [`ROW_WIDTH-1:0]        req_rd_row, issue_row;
  logic                         issue_valid, issue_ready, issue_row_open, issue_last;
  logic [QW-1:0]                issue_req_id;
`ifdef BATCH_DISPATCH_STATS_EN
  logic [RW-1:0]                stat_rows_opened;
  logic [QW-1:0]                stat_reqs_issued;
`endif

  batch_dispatcher #(.RD_LAT(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .busy              (busy),
    .done              (done),
    .critical_path_sbr (critical_path_sbr),
    .sbr_num_entries   (sbr_num_entries),
    .sbr_rd_addr       (sbr_rd_addr),
    .sbr_rd_head_srr   (sbr_rd_head_srr),
    .sbr_rd_row_count  (sbr_rd_row_count),
    .srr_rd_addr       (srr_rd_addr),
    .srr_rd_head_req   (srr_rd_head_req),
    .srr_rd_count      (srr_rd_count),
    .srr_rd_next       (srr_rd_next),
    .req_rd_addr       (req_rd_addr),
    .req_rd_bank_group (req_rd_bank_group),
    .req_rd_bank       (req_rd_bank),
    .req_rd_row        (req_rd_row),
    .req_rd_next       (req_rd_next),
    .issue_valid       (issue_valid),
    .issue_ready       (issue_ready),
    .issue_req_id      (issue_req_id),
    .issue_bank_group  (issue_bank_group),
    .issue_bank        (issue_bank),
    .issue_row         (issue_row),
    .issue_row_open    (issue_row_open),
    .issue_last        (issue_last)
`ifdef BATCH_DISPATCH_STATS_EN
    ,
    .stat_rows_opened  (stat_rows_opened),
    .stat_reqs_issued  (stat_reqs_issued)
`endif
  );

  always #5 clk = ~clk;

  // Table memories; one register stage gives a two-cycle address-to-sample latency.
  logic [RW-1:0] sbr_head [16];
  logic [RW-1:0] sbr_rows [16];
  logic [QW-1:0] srr_head [64];
  logic [QW-1:0] srr_cnt  [64];
  logic [RW-1:0] srr_nxt  [64];
  logic [QW-1:0] req_nxt  [64];

  always @(posedge clk) begin
    sbr_rd_head_srr   <= sbr_head[sbr_rd_addr];
    sbr_rd_row_count  <= sbr_rows[sbr_rd_addr];
    srr_rd_head_req   <= srr_head[srr_rd_addr];
    srr_rd_count      <= srr_cnt[srr_rd_addr];
    srr_rd_next       <= srr_nxt[srr_rd_addr];
    req_rd_next       <= req_nxt[req_rd_addr];
    req_rd_bank_group <= req_rd_addr[1:0];
    req_rd_bank       <= req_rd_addr[3:2];
    req_rd_row        <= 16'h0100 + 16'(req_rd_addr);
  end

  typedef struct { int id; int open; int last; int bg; int bank; int row; } cap_t;
  typedef struct { int scn; int id; int open; int last; } vec_t;

  cap_t got[$];
  vec_t vec [NVEC];
  int   done_cnt = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(negedge clk) begin
    if (!rst && issue_valid && issue_ready) begin
      got.push_back('{int'(issue_req_id), int'(issue_row_open), int'(issue_last),
                      int'(issue_bank_group), int'(issue_bank), int'(issue_row)});
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctrl"}, int'({issue_valid, busy, done, issue_row_open, issue_last}), 0);
    check({tag, "_addr"}, int'({sbr_rd_addr, srr_rd_addr, req_rd_addr}), 0);
    check({tag, "_fields"}, int'({issue_req_id, issue_bank_group, issue_bank, issue_row}), 0);
  endtask

  task automatic start_batch(input int num, input int crit);
    sbr_num_entries   = SW'(num);
    critical_path_sbr = SW'(crit);
    got.delete();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    int seen = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    check({tag, "_done_seen"}, seen, 1);
    @(posedge clk); #1;
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_busy_after"}, int'({busy, done}), 0);
  endtask

  task automatic wait_valid(input string tag);
    int seen = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (issue_valid) begin
        seen = 1;
        break;
      end
    end
    check({tag, "_valid_seen"}, seen, 1);
  endtask

  task automatic check_seq(input int scn);
    int k = 0;
    for (int i = 0; i < NVEC; i++) begin
      if (vec[i].scn == scn) begin
        if (k < got.size()) begin
          check($sformatf("s%0d_%0d_id", scn, k), got[k].id, vec[i].id);
          check($sformatf("s%0d_%0d_open", scn, k), got[k].open, vec[i].open);
          check($sformatf("s%0d_%0d_last", scn, k), got[k].last, vec[i].last);
          check($sformatf("s%0d_%0d_row", scn, k), got[k].row, 'h100 + vec[i].id);
          check($sformatf("s%0d_%0d_bgbank", scn, k), got[k].bg + 4 * got[k].bank,
                vec[i].id % 16);
        end
        k++;
      end
    end
    check($sformatf("s%0d_count", scn), got.size(), k);
  endtask

  task automatic set_sbr(input int idx, input int head, input int rows);
    sbr_head[idx] = RW'(head);
    sbr_rows[idx] = RW'(rows);
  endtask

  task automatic set_srr(input int idx, input int head, input int cnt, input int nxt);
    srr_head[idx] = QW'(head);
    srr_cnt[idx]  = QW'(cnt);
    srr_nxt[idx]  = RW'(nxt);
  endtask

  initial begin
    int d0;
    int snap [6];

    // Expected issue order: {scenario, id, row_open, last}.
    vec[0]  = '{1, 0, 1, 0};  vec[1]  = '{1, 3, 0, 0};  vec[2]  = '{1, 5, 0, 1};
    vec[3]  = '{2, 40, 1, 0}; vec[4]  = '{2, 10, 1, 0}; vec[5]  = '{2, 11, 0, 0};
    vec[6]  = '{2, 20, 1, 0}; vec[7]  = '{2, 30, 1, 0}; vec[8]  = '{2, 31, 0, 1};
    vec[9]  = '{3, 10, 1, 0}; vec[10] = '{3, 11, 0, 0}; vec[11] = '{3, 20, 1, 0};
    vec[12] = '{3, 30, 1, 0}; vec[13] = '{3, 31, 0, 1};
    vec[14] = '{4, 50, 1, 0}; vec[15] = '{4, 51, 0, 0}; vec[16] = '{4, 52, 0, 0};
    vec[17] = '{4, 60, 1, 0}; vec[18] = '{4, 61, 0, 1};

    for (int i = 0; i < 16; i++) set_sbr(i, 0, 0);
    for (int i = 0; i < 64; i++) begin
      set_srr(i, 0, 0, 0);
      req_nxt[i] = '0;
    end
    set_srr(0, 0, 3, 0);  req_nxt[0] = 6'd3;  req_nxt[3] = 6'd5;
    set_srr(1, 10, 2, 0); req_nxt[10] = 6'd11;
    set_srr(2, 20, 1, 3);
    set_srr(3, 30, 2, 0); req_nxt[30] = 6'd31;
    set_srr(4, 40, 1, 0);
    set_srr(5, 50, 3, 7); req_nxt[50] = 6'd51; req_nxt[51] = 6'd52;
    set_srr(7, 0, 0, 6);
    set_srr(6, 60, 2, 0); req_nxt[60] = 6'd61;

    rst = 1'b1; start = 1'b0; issue_ready = 1'b1;
    critical_path_sbr = '0; sbr_num_entries = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Empty batch.
    d0 = done_cnt;
    start_batch(0, 0);
    @(negedge clk);
    check("empty_busy_high", int'(busy), 1);
    wait_done("empty", d0);
    check("empty_no_issue", got.size(), 0);

    // One SBR, one SRR chaining 0 -> 3 -> 5.
    set_sbr(0, 0, 1);
    d0 = done_cnt;
    start_batch(1, 0);
    wait_done("one", d0);
    check_seq(1);

    // Three SBRs with the critical one last in index order.
    set_sbr(0, 1, 1); set_sbr(1, 2, 2); set_sbr(2, 4, 1);
    d0 = done_cnt;
    start_batch(3, 2);
    wait_done("three", d0);
    check_seq(2);
`ifdef BATCH_DISPATCH_STATS_EN
    check("three_stat_rows", int'(stat_rows_opened), 4);
    check("three_stat_reqs", int'(stat_reqs_issued), 6);
`endif

    // Critical SBR out of range is skipped.
    d0 = done_cnt;
    start_batch(2, 5);
    wait_done("crit_oor", d0);
    check_seq(3);

    // Two populated SRRs around an empty one.
    set_sbr(0, 5, 3);
    d0 = done_cnt;
    start_batch(1, 0);
    wait_done("stats", d0);
    check_seq(4);
`ifdef BATCH_DISPATCH_STATS_EN
    check("stats_rows", int'(stat_rows_opened), 2);
    check("stats_reqs", int'(stat_reqs_issued), 5);
    repeat (3) @(posedge clk);
    #1 check("stats_hold", int'(stat_reqs_issued), 5);
`endif

    // Backpressure on the second request.
    set_sbr(0, 0, 1);
    d0 = done_cnt;
    start_batch(1, 0);
    for (int i = 0; i < 500 && got.size() < 1; i++) begin
      @(posedge clk); #1;
    end
    issue_ready = 1'b0;
    wait_valid("bp");
    check("bp_held_id", int'(issue_req_id), 3);
    snap[0] = int'(issue_req_id);
    snap[1] = int'({issue_row_open, issue_last, issue_bank_group, issue_bank});
    snap[2] = int'(issue_row);
    snap[3] = int'(req_rd_addr);
    snap[4] = int'(srr_rd_addr);
    snap[5] = int'(sbr_rd_addr);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      check($sformatf("bp_valid_c%0d", c), int'(issue_valid), 1);
      check($sformatf("bp_id_c%0d", c), int'(issue_req_id), snap[0]);
      check($sformatf("bp_flags_c%0d", c),
            int'({issue_row_open, issue_last, issue_bank_group, issue_bank}), snap[1]);
      check($sformatf("bp_row_c%0d", c), int'(issue_row), snap[2]);
      check($sformatf("bp_addrs_c%0d", c),
            int'({req_rd_addr, srr_rd_addr, sbr_rd_addr}),
            int'({QW'(snap[3]), RW'(snap[4]), SW'(snap[5])}));
    end
    @(posedge clk); #1 issue_ready = 1'b1;
    wait_done("bp", d0);
    check_seq(1);

    // Reset while an issue is pending, then re-dispatch from the critical SBR.
    set_sbr(0, 1, 1);
    issue_ready = 1'b0;
    start_batch(3, 2);
    wait_valid("rst");
    d0 = done_cnt;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("midrst");
    @(posedge clk); #1;
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_no_issue", got.size(), 0);
    issue_ready = 1'b1;
    d0 = done_cnt;
    start_batch(3, 2);
    wait_done("redispatch", d0);
    check_seq(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/batch_dispatcher.md
Name: batch_dispatcher

Overview:
- Read-side counterpart of the batch scheduler. After a batch is built, it walks the SBR, SRR and request linked lists and issues requests one at a time on a valid/ready port to the command generator.
- Order: critical-path SBR first, then every other SBR in ascending index. Within an SBR, SRRs follow chain order. Within an SRR, requests follow chain order.
- Sits between the SRR/SBR/request tables and the DRAM command stage.

Parameters:
- RD_LAT, 2, table read latency in cycles from address register to sampled data; legal values 1..3.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin dispatch of the current batch; ignored unless idle
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the batch is fully issued
- critical_path_sbr  in  `SBR_ID_WIDTH  SBR to dispatch first
- sbr_num_entries  in  `SBR_ID_WIDTH  number of valid SBRs
- sbr_rd_addr  out  `SBR_ID_WIDTH  SBR table read address
- sbr_rd_head_srr  in  `SRR_ID_WIDTH  first SRR of the addressed SBR
- sbr_rd_row_count  in  `SRR_ID_WIDTH  number of SRRs in the addressed SBR
- srr_rd_addr  out  `SRR_ID_WIDTH  SRR table read address
- srr_rd_head_req  in  `REQUEST_ID_WIDTH  first request of the addressed SRR
- srr_rd_count  in  `REQUEST_ID_WIDTH  number of requests in the addressed SRR
- srr_rd_next  in  `SRR_ID_WIDTH  SRR chain pointer
- req_rd_addr  out  `REQUEST_ID_WIDTH  request buffer read address
- req_rd_bank_group  in  `BANK_GROUP_WIDTH  request field
- req_rd_bank  in  `BANK_WIDTH  request field
- req_rd_row  in  `ROW_WIDTH  request field
- req_rd_next  in  `REQUEST_ID_WIDTH  request chain pointer
- issue_valid  out  1  request presented
- issue_ready  in  1  downstream accepts
- issue_req_id  out  `REQUEST_ID_WIDTH  request index
- issue_bank_group  out  `BANK_GROUP_WIDTH
- issue_bank  out  `BANK_WIDTH
- issue_row  out  `ROW_WIDTH
- issue_row_open  out  1  first request of its SRR (activate required)
- issue_last  out  1  final request of the batch

Behaviour:
- Reset (rst sampled high at a clk edge): all outputs 0, state IDLE, counters 0. Takes effect mid-batch; a pending issue is dropped and no done pulse is produced.
- Table reads: an address registered at edge t is sampled at edge t+RD_LAT. A single wait counter counts RD_LAT.
- Chain walking is count-terminated. The SRR walk stops after row_count SRRs and the request walk stops after count requests. Pointers are never checked for a null value.
- States:
  - IDLE: on start, go to SEL_SBR with sbr_idx=0 and first=1.
  - SEL_SBR:
    - If first=1, target = critical_path_sbr.
    - Otherwise, if sbr_idx == critical_path_sbr, increment sbr_idx. Then if sbr_idx >= sbr_num_entries, go to DONE; else target = sbr_idx.
    - Drive sbr_rd_addr = target and go to RD_SBR.
  - RD_SBR: after RD_LAT, latch head_srr and rows_left = row_count. If rows_left == 0, go to NEXT_SBR; else go to RD_SRR.
  - RD_SRR: after RD_LAT, latch head_req, reqs_left = count, next_srr, and row_open=1. If reqs_left == 0, go to ADV_SRR; else go to RD_REQ.
  - RD_REQ: after RD_LAT, latch the fields and next_req into the output registers, assert issue_valid, go to ISSUE.
  - ISSUE: hold all issue_* stable while issue_valid && !issue_ready. On the accepting edge:
    - Deassert issue_valid, clear row_open, decrement reqs_left.
    - If nonzero, load req_rd_addr = next_req and go to RD_REQ; else go to ADV_SRR.
  - ADV_SRR: decrement rows_left. If nonzero, srr_rd_addr = next_srr and go to RD_SRR; else go to NEXT_SBR.
  - NEXT_SBR: if first=1, clear first; otherwise increment sbr_idx. Then go to SEL_SBR.
  - DONE: pulse done for one cycle and return to IDLE. busy falls on the same edge.
- issue_last is asserted with the final issued request. It is computed at RD_REQ load time as reqs_left==1 && rows_left==1 && no further SBR remains. Any remaining SBRs are assumed non-empty.
- critical_path_sbr >= sbr_num_entries, or sbr_num_entries == 0: the critical SBR is skipped and DONE follows immediately when no SBRs exist. No issue occurs in that case.
- Throughput: one request per (RD_LAT+1) cycles when issue_ready is held high.
- Counters wrap modulo their declared width; no saturation.
- start while busy is ignored. start and rst in the same cycle: rst wins.

Optional Feature:
- BATCH_DISPATCH_STATS_EN
- Defined: adds outputs stat_rows_opened (`SRR_ID_WIDTH) and stat_reqs_issued (`REQUEST_ID_WIDTH).
  - stat_rows_opened increments on each accepted issue with issue_row_open=1.
  - stat_reqs_issued increments on each accepted issue.
  - Both clear on rst and on accepted start, and hold after done.
- Undefined: these ports and their counters are absent; all other behaviour is identical.

Test Plan:
- Empty batch: sbr_num_entries=0, start -> no issue_valid; done pulses once; busy returns 0.
- One SBR (row_count=1), one SRR holding requests 0,3,5 linked 0->3->5, issue_ready=1 -> ids 0,3,5 issued in order; row_open=1 only on id 0; issue_last only on id 5.
- Three SBRs, critical_path_sbr=2 -> all of SBR2's requests are issued before SBR0's, then SBR1's; SBR2 is never issued twice.
- Backpressure: issue_ready held 0 for 7 cycles on the second request -> issue_* remain stable; no table reads advance; the request is issued once when ready rises.
- Reset mid-dispatch: rst asserted while in ISSUE -> next cycle all outputs 0; a following start re-dispatches the batch from the critical SBR.
- BATCH_DISPATCH_STATS_EN defined, 2 SRRs with 3 and 2 requests -> stat_rows_opened=2, stat_reqs_issued=5 at done.
